i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
- REQ-001 SHALL have parameter AUDIO_DW, default 16: sample width in bits, range 1..32.
- REQ-002 SHALL have parameter SLOT_DW, default 32: slot width in sclk periods, range AUDIO_DW..32.
- REQ-003 SHALL have parameter I2S_FREQ, default 48_000: frame rate in Hz.
- REQ-004 clk  in  1  sole clock; all logic on posedge.
- REQ-005 reset  in  1  asynchronous, active-high reset.
- REQ-006 clk_rate  in  32  clk frequency in Hz.
- REQ-007 mode  in  2  format select: 0 = I2S, 1 = left-justified (LJ), 2 = right-justified (RJ), 3 = treated as 0.
- REQ-008 sample_valid  in  1  left_chan/right_chan hold a new stereo sample.
- REQ-009 left_chan, right_chan  in  AUDIO_DW each  sample data, two's complement, MSB first.
- REQ-010 sample_ready  out  1  one-clk pulse at frame start; a transfer occurs when sample_valid && sample_ready.
- REQ-011 underrun  out  1  one-clk pulse when sample_ready fires with sample_valid low.
- REQ-012 sclk, lrclk, sdata  out  1 each  serial bit clock, word select and data; all registered.

Function
- REQ-013 Clock-enable generator SHALL keep a 32-bit accumulator cnt.
  - Each clk: nxt = cnt + I2S_FREQ*4*SLOT_DW.
  - If nxt >= clk_rate: cnt <= nxt - clk_rate and ce pulses for one clk.
  - Otherwise: cnt <= nxt.
- REQ-014 Each ce SHALL toggle sclk; one sclk period = two ce.
- REQ-015 State changes SHALL occur only on the ce that drives sclk 1->0 (the falling edge); the receiver samples on the rising edge.
- REQ-016 Bit position pos SHALL be a counter over 0..2*SLOT_DW-1.
  - Increments on each falling edge; wraps from 2*SLOT_DW-1 to 0.
  - pos < SLOT_DW is the left slot; pos >= SLOT_DW is the right slot.
- REQ-017 Frame start is the falling edge on which pos becomes 0. On that clk SHALL:
  - latch mode into mode_q;
  - pulse sample_ready;
  - if sample_valid: load left_chan/right_chan into sample registers;
  - else: keep the previous sample and pulse underrun.
- REQ-018 lrclk SHALL equal the slot bit (0 = left) when mode_q is I2S, and its inverse (1 = left) when mode_q is LJ or RJ; it changes on the falling edge.
- REQ-019 LJ stream: at slot bit b, sdata = sample bit (AUDIO_DW-1-b) for b < AUDIO_DW; otherwise 0.
- REQ-020 RJ stream: at slot bit b, sdata = sample bit (SLOT_DW-1-b) for b >= SLOT_DW-AUDIO_DW; otherwise 0.
- REQ-021 I2S stream SHALL be the LJ stream delayed by exactly one sclk period.
  - The LSB of a right slot appears at pos 0 of the next frame when AUDIO_DW == SLOT_DW.
- REQ-022 A mode change mid-frame SHALL take effect only at the next frame start; the first I2S bit after a switch from LJ/RJ is 0.
- REQ-023 If clk_rate <= I2S_FREQ*4*SLOT_DW, ce SHALL assert every clk; no other behaviour changes.

Reset
- REQ-024 While reset is high, SHALL hold: cnt = 0, ce = 0, sclk = 1, pos = 2*SLOT_DW-1, mode_q = 0, lrclk = 1, sdata = 0, delay bit = 0, sample registers = 0, sample_ready = 0, underrun = 0.
- REQ-025 Reset assertion mid-frame SHALL abort the frame immediately and lose no sample already accepted.
- REQ-026 After release, the first falling edge SHALL be a frame start.

Verification
- REQ-027 Rate: I2S_FREQ=48000, SLOT_DW=16, clk_rate=24_576_000 -> ce every 8 clk; sclk period 16 clk; lrclk period 512 clk.
- REQ-028 LJ: AUDIO_DW=16, SLOT_DW=16, mode=1, left=16'hA5F0, right=16'h0F0F, valid held -> left slot bits 1010010111110000 with lrclk=1, then right slot 0000111100001111 with lrclk=0.
- REQ-029 I2S: same data, mode=0 -> identical bit sequence shifted one sclk later; lrclk=0 on the left slot; first bit of the left slot is the previous right LSB (1).
- REQ-030 RJ: AUDIO_DW=16, SLOT_DW=24, mode=2, left=16'h8001 -> left slot is 8 zeros, then 1000000000000001.
- REQ-031 Underrun: sample_valid low at a frame start -> underrun pulses exactly 1 clk concurrent with sample_ready; previous sample retransmitted bit-exact.
- REQ-032 Reset mid-frame (pos=10) -> outputs immediately at REQ-024 values; after release, sample_ready pulses on the first falling edge and a fresh sample is loaded.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S / left-justified / right-justified stereo serializer.
// Bit clock is derived from clk by a fractional phase accumulator; all outputs are registered.
module i2s_tx #(
  parameter int unsigned AUDIO_DW = 16,
  parameter int unsigned SLOT_DW  = 32,
  parameter int unsigned I2S_FREQ = 48_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         clk_rate,
  input  logic [1:0]          mode,
  input  logic                sample_valid,
  input  logic [AUDIO_DW-1:0] left_chan,
  input  logic [AUDIO_DW-1:0] right_chan,
  output logic                sample_ready,
  output logic                underrun,
  output logic                sclk,
  output logic                lrclk,
  output logic                sdata
);

  localparam int unsigned     PW      = $clog2(2 * SLOT_DW);
  localparam logic [PW-1:0]   PosLast = PW'(2 * SLOT_DW - 1);
  localparam logic [PW-1:0]   SlotW   = PW'(SLOT_DW);
  localparam logic [32:0]     Inc     = 33'(I2S_FREQ * 4 * SLOT_DW);
  localparam logic [1:0]      ModeI2s = 2'd0;
  localparam logic [1:0]      ModeRj  = 2'd2;

  logic [31:0]         cnt_q;
  logic [32:0]         nxt;
  logic                ce_q;
  logic                sclk_q, lrclk_q, sdata_q, dly_q;
  logic [PW-1:0]       pos_q, pos_d;
  logic [1:0]          mode_q, mode_d;
  logic [AUDIO_DW-1:0] left_q, left_d, right_q, right_d, smp;
  logic                fall, frame_start, slot, is_i2s, lj_bit, rj_bit;
  logic [PW-1:0]       bit_pos;
  logic [4:0]          b5;
  logic [31:0]         lj_al, rj_al;

  always_comb nxt = {1'b0, cnt_q} + Inc;

  // Phase accumulator: ce fires once for every clk_rate worth of accumulated Inc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else if (nxt >= {1'b0, clk_rate}) begin
      cnt_q <= 32'(nxt - {1'b0, clk_rate});
      ce_q  <= 1'b1;
    end else begin
      cnt_q <= nxt[31:0];
      ce_q  <= 1'b0;
    end
  end

  always_comb begin
    fall        = ce_q & sclk_q;
    frame_start = fall && (pos_q == PosLast);
    pos_d       = (pos_q == PosLast) ? '0 : pos_q + 1'b1;
    mode_d      = mode_q;
    left_d      = left_q;
    right_d     = right_q;
    if (frame_start) begin
      mode_d = (mode == 2'd3) ? ModeI2s : mode;
      if (sample_valid) begin
        left_d  = left_chan;
        right_d = right_chan;
      end
    end
    slot    = (pos_d >= SlotW);
    bit_pos = slot ? pos_d - SlotW : pos_d;
    b5      = 5'(bit_pos);
    smp     = slot ? right_d : left_d;
    // Left-align for LJ, slot-right-align for RJ; bit b of the slot is then vector bit 31-b.
    lj_al   = 32'(smp) << (32 - AUDIO_DW);
    rj_al   = 32'(smp) << (32 - SLOT_DW);
    lj_bit  = lj_al[~b5];
    rj_bit  = rj_al[~b5];
    is_i2s  = (mode_d == ModeI2s);
  end

  assign sample_ready = frame_start;
  assign underrun     = frame_start & ~sample_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q  <= 1'b1;
      pos_q   <= PosLast;
      mode_q  <= ModeI2s;
      lrclk_q <= 1'b1;
      sdata_q <= 1'b0;
      dly_q   <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else if (fall) begin
      sclk_q  <= 1'b0;
      pos_q   <= pos_d;
      mode_q  <= mode_d;
      left_q  <= left_d;
      right_q <= right_d;
      lrclk_q <= is_i2s ? slot : ~slot;
      sdata_q <= is_i2s ? dly_q : ((mode_d == ModeRj) ? rj_bit : lj_bit);
      // Delay stage only tracks the LJ stream in I2S mode, so a switch into I2S starts with 0.
      dly_q   <= is_i2s ? lj_bit : 1'b0;
    end else if (ce_q) begin
      sclk_q <= 1'b1;
    end
  end

  assign sclk  = sclk_q;
  assign lrclk = lrclk_q;
  assign sdata = sdata_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized bench for i2s_tx: two instances (16-bit samples in 16- and 24-bit slots)
// checked frame by frame against a format model built from the bit-placement rules.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] clk_rate;
  logic [1:0]  mode;
  logic        sample_valid;
  logic [15:0] left_chan, right_chan;
  logic [1:0]  sr, ur, sc, lr, sd;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int nframes = 0;
  int exp_half[2];
  int exp_frame[2];

  // Receiver-side model state per instance
  logic [63:0] cap_d[2], cap_l[2];
  int          nb[2], ntog[2], last_tog[2], last_sr[2];
  logic        prev_sclk[2], active[2], prev_i2s[2], prev_last[2];
  logic [1:0]  m_mode[2];
  logic [15:0] m_l[2], m_r[2];

  i2s_tx #(.AUDIO_DW(16), .SLOT_DW(16), .I2S_FREQ(48_000)) dut16 (
    .clk(clk), .reset(reset), .clk_rate(clk_rate), .mode(mode),
    .sample_valid(sample_valid), .left_chan(left_chan), .right_chan(right_chan),
    .sample_ready(sr[0]), .underrun(ur[0]), .sclk(sc[0]), .lrclk(lr[0]), .sdata(sd[0])
  );

  i2s_tx #(.AUDIO_DW(16), .SLOT_DW(24), .I2S_FREQ(48_000)) dut24 (
    .clk(clk), .reset(reset), .clk_rate(clk_rate), .mode(mode),
    .sample_valid(sample_valid), .left_chan(left_chan), .right_chan(right_chan),
    .sample_ready(sr[1]), .underrun(ur[1]), .sclk(sc[1]), .lrclk(lr[1]), .sdata(sd[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slot_w(input int d);
    return (d == 0) ? 16 : 24;
  endfunction

  function automatic logic lj_at(input int s, input logic [15:0] l, input logic [15:0] r,
                                 input int p);
    int b;
    logic [15:0] v;
    b = p % s;
    v = (p < s) ? l : r;
    if (b < 16) return v[4'(15 - b)];
    return 1'b0;
  endfunction

  function automatic logic rj_at(input int s, input logic [15:0] l, input logic [15:0] r,
                                 input int p);
    int b;
    logic [15:0] v;
    b = p % s;
    v = (p < s) ? l : r;
    if (b >= s - 16) return v[4'(s - 1 - b)];
    return 1'b0;
  endfunction

  // Serial word of one frame, bit at position 0 ends up most significant.
  function automatic logic [63:0] exp_data(input int s, input logic [1:0] m,
                                           input logic [15:0] l, input logic [15:0] r,
                                           input logic first);
    logic [63:0] w;
    logic        bt;
    w = '0;
    for (int p = 0; p < 2 * s; p++) begin
      if (m == 2'd0)      bt = (p == 0) ? first : lj_at(s, l, r, p - 1);
      else if (m == 2'd2) bt = rj_at(s, l, r, p);
      else                bt = lj_at(s, l, r, p);
      w = {w[62:0], bt};
    end
    return w;
  endfunction

  function automatic logic [63:0] exp_lr(input int s, input logic [1:0] m);
    logic [63:0] w;
    w = '0;
    for (int p = 0; p < 2 * s; p++) w = {w[62:0], (m == 2'd0) ? (p >= s) : (p < s)};
    return w;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        prev_sclk[d] = 1'b1; active[d] = 1'b0; prev_i2s[d] = 1'b0; prev_last[d] = 1'b0;
        m_mode[d] = 2'd0; m_l[d] = '0; m_r[d] = '0; nb[d] = 0; ntog[d] = 0;
        last_tog[d] = -1; last_sr[d] = -1; cap_d[d] = '0; cap_l[d] = '0;
      end else begin
        if (sc[d] != prev_sclk[d]) begin
          if (last_tog[d] >= 0 && exp_half[d] != 0)
            check("half_period", 64'(cyc - last_tog[d]), 64'(exp_half[d]));
          last_tog[d] = cyc;
          ntog[d]++;
          if (sc[d] && active[d] && nb[d] < 64) begin
            cap_d[d] = {cap_d[d][62:0], sd[d]};
            cap_l[d] = {cap_l[d][62:0], lr[d]};
            nb[d]++;
          end
        end
        prev_sclk[d] = sc[d];
        if (ur[d]) check("underrun_needs_ready", 64'(sr[d]), 64'd1);
        if (sr[d]) begin
          if (active[d]) begin
            check("frame_bits", 64'(nb[d]), 64'(2 * slot_w(d)));
            check("sdata_frame", cap_d[d],
                  exp_data(slot_w(d), m_mode[d], m_l[d], m_r[d],
                           prev_i2s[d] ? prev_last[d] : 1'b0));
            check("lrclk_frame", cap_l[d], exp_lr(slot_w(d), m_mode[d]));
            prev_i2s[d]  = (m_mode[d] == 2'd0);
            prev_last[d] = lj_at(slot_w(d), m_l[d], m_r[d], 2 * slot_w(d) - 1);
            nframes++;
          end else begin
            check("first_fall_is_frame_start", 64'(ntog[d]), 64'd0);
          end
          if (last_sr[d] >= 0 && exp_frame[d] != 0)
            check("frame_period", 64'(cyc - last_sr[d]), 64'(exp_frame[d]));
          check("underrun", 64'(ur[d]), 64'(!sample_valid));
          m_mode[d] = (mode == 2'd3) ? 2'd0 : mode;
          if (sample_valid) begin
            m_l[d] = left_chan;
            m_r[d] = right_chan;
          end
          active[d] = 1'b1; nb[d] = 0; cap_d[d] = '0; cap_l[d] = '0; last_sr[d] = cyc;
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_sclk", 64'(sc), 64'(2'b11));
    check("rst_lrclk", 64'(lr), 64'(2'b11));
    check("rst_sdata", 64'(sd), 64'd0);
    check("rst_ready", 64'(sr), 64'd0);
    check("rst_underrun", 64'(ur), 64'd0);
  endtask

  task automatic randomize_inputs();
    mode         = 2'($urandom_range(0, 3));
    sample_valid = ($urandom_range(0, 3) != 0);
    left_chan    = 16'($urandom);
    right_chan   = 16'($urandom);
  endtask

  initial begin
    int waited;
    reset = 1'b1; clk_rate = 32'd24_576_000; mode = 2'd1; sample_valid = 1'b1;
    left_chan = 16'hA5F0; right_chan = 16'h0F0F;
    exp_half = '{8, 0}; exp_frame = '{512, 512};
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    reset = 1'b0;

    // Directed LJ, then I2S, then RJ with a one-hot-ish sample
    repeat (1100) @(posedge clk);
    #1 mode = 2'd0;
    repeat (1600) @(posedge clk);
    #1 mode = 2'd2; left_chan = 16'h8001;
    repeat (1100) @(posedge clk);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(50, 900)) @(posedge clk);
      #1 randomize_inputs();
    end

    // Reset roughly ten bits into a frame
    waited = 0;
    while (sr[0] !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("wait_ready", 64'(sr[0]), 64'd1);
    repeat (165) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_outputs();
    repeat (4) @(posedge clk);
    #1 mode = 2'd1; sample_valid = 1'b1; left_chan = 16'h1234; right_chan = 16'hFEDC;
    reset = 1'b0;
    repeat (1600) @(posedge clk);

    // clk_rate below the bit-clock demand: ce every clk
    #1 reset = 1'b1;
    clk_rate = 32'd1_000_000;
    exp_half = '{1, 1}; exp_frame = '{64, 96};
    repeat (2) @(posedge clk);
    #1 check_reset_outputs();
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(20, 150)) @(posedge clk);
      #1 randomize_inputs();
    end
    repeat (200) @(posedge clk);

    check("frames_seen", 64'(nframes >= 60), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
